memory_arbiter: RTL and testbench

Serialises the CPU's two memory ports, the instruction fetch and the MEM-stage data access, onto one single-port memory with a req/ack handshake. It sits directly downstream of `cpu`:

- Inputs: `address`, `address2`, `memRead2`, `memWrite`, `writeData`.
- Outputs: `readData` and `readData2`, plus a stall that freezes the whole pipeline until both accesses of the current CPU cycle complete.

Each CPU step performs the data access first (if any), then the instruction fetch. An ack-timeout watchdog prevents a dead memory from hanging the core.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/ack_timer.sv | 45 ++++
 rtl/memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_memory_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared definitions for the CPU memory arbiter
//
// Purpose: state encoding of the arbiter FSM and the default timeout data word.
// Ports:   none (package).

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - clearable 16-bit ack watchdog with terminal-count flag
//
// Purpose: counts wait cycles of an outstanding memory request.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous, active-high
//   clear    in   return the count to zero (wins over enable)
//   enable   in   count one more wait cycle
//   expired  out  count has reached TimeoutCycles-1

module ack_timer #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LastCount = 16'(TimeoutCycles - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LastCount);

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - serialises CPU data access and instruction fetch onto one memory port
//
// Purpose: each CPU step runs the data access (if any) then the fetch, stalling
//          the CPU until both complete; a watchdog forces completion on a dead memory.
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   instrAddress / instrData          fetch address in, fetched word out
//   dataAddress, dataRead, dataWrite,
//   dataWriteData / dataReadData      data access in, load result out
//   cpuStall                          high while the CPU must hold its pipeline
//   memReq, memWe, memAddr, memWdata  request to memory
//   memAck, memRdata                  completion and read data from memory
//   memError                          sticky timeout flag

module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [31:0] ErrorData     = ERROR_DATA_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrAddress,
  output logic [31:0] instrData,
  input  logic [31:0] dataAddress,
  input  logic        dataRead,
  input  logic        dataWrite,
  input  logic [31:0] dataWriteData,
  output logic [31:0] dataReadData,
  output logic        cpuStall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        memError
);

  arb_state_e  state_q;
  logic [31:0] cap_iaddr_q;
  logic [31:0] cap_daddr_q;
  logic [31:0] cap_wdata_q;
  logic        cap_write_q;
  logic [31:0] instr_data_q;
  logic [31:0] data_read_q;
  logic        mem_error_q;

  logic        in_req;
  logic        expired;
  logic        timed_out;
  logic        complete;
  logic [31:0] resp_data;

  assign in_req    = (state_q == DATA) || (state_q == INSTR);
  // A real ack in the terminal-count cycle wins over the timeout.
  assign timed_out = in_req && !memAck && expired;
  assign complete  = in_req && (memAck || expired);
  assign resp_data = memAck ? memRdata : ErrorData;

  // Clearing on completion and outside request states restarts the count at
  // every state entry, including the DATA->INSTR hand-over.
  ack_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_ack_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_req || complete),
    .enable (in_req && !memAck),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cap_iaddr_q  <= '0;
      cap_daddr_q  <= '0;
      cap_wdata_q  <= '0;
      cap_write_q  <= 1'b0;
      instr_data_q <= '0;
      data_read_q  <= '0;
      mem_error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cap_iaddr_q <= instrAddress;
          cap_daddr_q <= dataAddress;
          cap_wdata_q <= dataWriteData;
          // Read and write together resolve to a write.
          cap_write_q <= dataWrite;
          state_q     <= (dataRead || dataWrite) ? DATA : INSTR;
        end
        DATA: begin
          if (complete) begin
            if (!cap_write_q) begin
              data_read_q <= resp_data;
            end
            if (timed_out) begin
              mem_error_q <= 1'b1;
            end
            state_q <= INSTR;
          end
        end
        INSTR: begin
          if (complete) begin
            instr_data_q <= resp_data;
            if (timed_out) begin
              mem_error_q <= 1'b1;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    memReq   = in_req;
    memWe    = (state_q == DATA) && cap_write_q;
    memAddr  = '0;
    memWdata = '0;
    if (state_q == DATA) begin
      memAddr  = cap_daddr_q;
      memWdata = cap_wdata_q;
    end else if (state_q == INSTR) begin
      memAddr = cap_iaddr_q;
    end
  end

  assign cpuStall     = (state_q != DONE);
  assign instrData    = instr_data_q;
  assign dataReadData = data_read_q;
  assign memError     = mem_error_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter

module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instrAddress = '0;
  logic [31:0] instrData;
  logic [31:0] dataAddress = '0;
  logic        dataRead = 1'b0;
  logic        dataWrite = 1'b0;
  logic [31:0] dataWriteData = '0;
  logic [31:0] dataReadData;
  logic        cpuStall;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic        memError;

  memory_arbiter #(
    .TimeoutCycles(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .instrAddress (instrAddress),
    .instrData    (instrData),
    .dataAddress  (dataAddress),
    .dataRead     (dataRead),
    .dataWrite    (dataWrite),
    .dataWriteData(dataWriteData),
    .dataReadData (dataReadData),
    .cpuStall     (cpuStall),
    .memReq       (memReq),
    .memWe        (memWe),
    .memAddr      (memAddr),
    .memWdata     (memWdata),
    .memAck       (memAck),
    .memRdata     (memRdata),
    .memError     (memError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          mute;
  } tx_t;

  tx_t         exp_q[$];
  logic [31:0] mem[logic [31:0]];
  int          total = 0;
  int          bad = 0;
  int          req_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory model: checks every request cycle against the scoreboard front,
  // acks after the transaction's wait count unless it is muted.
  always @(negedge clock) begin
    if (reset || !memReq) begin
      req_cyc  = 0;
      memAck   = 1'b0;
      memRdata = 32'h5555_AAAA;
    end else begin
      if (memAck) req_cyc = 0;
      req_cyc++;
      memAck   = 1'b0;
      memRdata = 32'h5555_AAAA;
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", exp_q.size(), 1);
      end else begin
        chk("mem_we", memWe, exp_q[0].we);
        chk("mem_addr", memAddr, exp_q[0].addr);
        chk("mem_wdata", memWdata, exp_q[0].wdata);
        if (!exp_q[0].mute && req_cyc > exp_q[0].waits) begin
          memAck = 1'b1;
          if (memWe) mem[memAddr] = memWdata;
          else memRdata = mem.exists(memAddr) ? mem[memAddr] : 32'h0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at the negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic step(input logic rd, input logic wr, input logic [31:0] daddr,
                      input logic [31:0] wdata, input logic [31:0] iaddr,
                      input int dwait, input int iwait, input bit imute,
                      input int exp_cyc, input logic [31:0] exp_i,
                      input logic [31:0] exp_d, input logic exp_err, input string tag);
    int  n;
    tx_t t;
    dataRead      = rd;
    dataWrite     = wr;
    dataAddress   = daddr;
    dataWriteData = wdata;
    instrAddress  = iaddr;
    if (rd || wr) begin
      t.we = wr; t.addr = daddr; t.wdata = wdata; t.waits = dwait; t.mute = 1'b0;
      exp_q.push_back(t);
    end
    t.we = 1'b0; t.addr = iaddr; t.wdata = '0; t.waits = iwait; t.mute = imute;
    exp_q.push_back(t);
    n = 1;
    while (cpuStall && n < 60) begin
      @(negedge clock);
      n++;
      if (n == 2) begin
        dataRead      = 1'b0;
        dataWrite     = 1'b0;
        dataAddress   = 32'hFFFF_FFF0;
        dataWriteData = 32'h0F0F_0F0F;
        instrAddress  = 32'hFFFF_FFFC;
      end
    end
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_instr"}, instrData, exp_i);
    chk({tag, "_dread"}, dataReadData, exp_d);
    chk({tag, "_err"}, memError, exp_err);
    if (imute && exp_q.size() > 0) void'(exp_q.pop_front());
    chk({tag, "_qempty"}, exp_q.size(), 0);
    @(negedge clock);
  endtask

  initial begin
    tx_t t;
    mem[32'h40]  = 32'h8C22_0004;
    mem[32'h44]  = 32'hAC03_0008;
    mem[32'h48]  = 32'h2042_0001;
    mem[32'h4C]  = 32'h0000_0013;
    mem[32'h100] = 32'h0000_1234;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", cpuStall, 1);
    chk("rst_req", memReq, 0);
    chk("rst_we", memWe, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_wdata", memWdata, 0);
    chk("rst_instr", instrData, 0);
    chk("rst_dread", dataReadData, 0);
    chk("rst_err", memError, 0);
    reset = 1'b0;

    step(0, 0, 32'h0,   32'h0,        32'h40, 0, 0, 0, 3, 32'h8C22_0004, 32'h0,        0, "fetch");
    step(1, 0, 32'h100, 32'h77,       32'h44, 0, 0, 0, 4, 32'hAC03_0008, 32'h1234,     0, "load");
    step(0, 1, 32'h200, 32'hCAFE_F00D, 32'h48, 3, 0, 0, 7, 32'h2042_0001, 32'h1234,    0, "store3w");
    step(1, 1, 32'h300, 32'h0BAD_F00D, 32'h4C, 0, 1, 0, 5, 32'h0000_0013, 32'h1234,    0, "rdwr");
    step(0, 0, 32'h0,   32'h0,        32'h50, 0, 0, 1, 6, 32'hDEAD_BEEF, 32'h1234,     1, "timeout");
    step(1, 0, 32'h300, 32'h0,        32'h40, 1, 0, 0, 5, 32'h8C22_0004, 32'h0BAD_F00D, 1, "sticky");

    // Reset in the middle of a muted data access.
    dataRead = 1'b1; dataWrite = 1'b0; dataAddress = 32'h100; dataWriteData = '0;
    instrAddress = 32'h44;
    t.we = 1'b0; t.addr = 32'h100; t.wdata = '0; t.waits = 0; t.mute = 1'b1;
    exp_q.push_back(t);
    @(negedge clock);
    chk("mid_req", memReq, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", memReq, 0);
    chk("mid_rst_stall", cpuStall, 1);
    chk("mid_rst_we", memWe, 0);
    chk("mid_rst_addr", memAddr, 0);
    chk("mid_rst_wdata", memWdata, 0);
    chk("mid_rst_instr", instrData, 0);
    chk("mid_rst_dread", dataReadData, 0);
    chk("mid_rst_err", memError, 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 32'h0, 32'h0, 32'h44, 0, 0, 0, 3, 32'hAC03_0008, 32'h0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
